// File: rtl/hazard_if.sv
// Hazard unit bus: pipeline-stage register tags, branch/memory status in,
// stall/flush/forwarding controls, sticky error and performance counters out.
//
// Memory handshake: mem_req is the memory stage's request and stays high
// until the access completes; mem_ready high in a cycle means the access
// completes in that cycle. A request is pending in a cycle where
// mem_req=1 and mem_ready=0.
interface hazard_if;
  // decode stage
  logic [2:0]  d_rs1;
  logic [2:0]  d_rs2;
  logic        d_use1;
  logic        d_use2;
  // execute stage
  logic [2:0]  e_rs1;
  logic [2:0]  e_rs2;
  logic [2:0]  e_rd;
  logic        e_write_reg;
  logic        e_load;
  // memory stage
  logic [2:0]  m_rd;
  logic        m_write_reg;
  // writeback stage
  logic [2:0]  w_rd;
  logic        w_write_reg;
  // control status
  logic        branch_taken;
  logic        mem_req;
  logic        mem_ready;
  // pipeline controls
  logic        stall_f;
  logic        stall_d;
  logic        stall_e;
  logic        stall_m;
  logic        flush_d;
  logic        flush_e;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  // status and counters
  logic        mem_timeout;
  logic [15:0] stall_cycles;
  logic [15:0] flush_events;
  // debug view of the FSM (0 = RUN, 1 = MEM_WAIT) and the wait counter
  logic        dbgState;
  logic [7:0]  dbgWaitCnt;

  // Pipeline side: drives stage tags and status, observes controls.
  modport master (
    output d_rs1, d_rs2, d_use1, d_use2,
    output e_rs1, e_rs2, e_rd, e_write_reg, e_load,
    output m_rd, m_write_reg, w_rd, w_write_reg,
    output branch_taken, mem_req, mem_ready,
    input  stall_f, stall_d, stall_e, stall_m, flush_d, flush_e,
    input  fwd_a, fwd_b, mem_timeout, stall_cycles, flush_events,
    input  dbgState, dbgWaitCnt
  );

  // Hazard unit side.
  modport slave (
    input  d_rs1, d_rs2, d_use1, d_use2,
    input  e_rs1, e_rs2, e_rd, e_write_reg, e_load,
    input  m_rd, m_write_reg, w_rd, w_write_reg,
    input  branch_taken, mem_req, mem_ready,
    output stall_f, stall_d, stall_e, stall_m, flush_d, flush_e,
    output fwd_a, fwd_b, mem_timeout, stall_cycles, flush_events,
    output dbgState, dbgWaitCnt
  );
endinterface

// File: rtl/hazard_unit.sv
// Five-stage pipeline hazard unit: operand forwarding, load-use interlock,
// branch flush, data-memory wait with timeout abort, and stall/flush
// performance counters. Register 0 is hardwired zero and never matches.
module hazard_unit #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input logic     clk,
  input logic     rst,
  hazard_if.slave bus
);

  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] MEM_WAIT = 1'b1;

  logic [0:0]  state;
  logic [0:0]  stateNext;
  logic [7:0]  waitCnt;
  logic        timeoutFlag;
  logic [15:0] stallCnt;
  logic [15:0] flushCnt;

  logic        memStall;
  logic        timeoutNow;
  logic        loadUse;
  logic        stallF;
  logic        stallD;
  logic        stallE;
  logic        stallM;
  logic        flushD;
  logic        flushE;

  // Forwarding select: memory-stage result beats writeback data; R0 never forwards.
  always_comb begin
    bus.fwd_a = 2'b00;
    bus.fwd_b = 2'b00;
    if (bus.m_write_reg && (bus.m_rd != 3'd0) && (bus.m_rd == bus.e_rs1))
      bus.fwd_a = 2'b10;
    else if (bus.w_write_reg && (bus.w_rd != 3'd0) && (bus.w_rd == bus.e_rs1))
      bus.fwd_a = 2'b01;
    if (bus.m_write_reg && (bus.m_rd != 3'd0) && (bus.m_rd == bus.e_rs2))
      bus.fwd_b = 2'b10;
    else if (bus.w_write_reg && (bus.w_rd != 3'd0) && (bus.w_rd == bus.e_rs2))
      bus.fwd_b = 2'b01;
  end

  // Load-use: a load in execute writes a register decode is about to read.
  always_comb begin
    loadUse = bus.e_load && bus.e_write_reg && (bus.e_rd != 3'd0) &&
              ((bus.d_use1 && (bus.d_rs1 == bus.e_rd)) ||
               (bus.d_use2 && (bus.d_rs2 == bus.e_rd)));
  end

  // Memory stall / timeout decode from the registered state.
  always_comb begin
    memStall   = 1'b0;
    timeoutNow = 1'b0;
    if (state == RUN) begin
      memStall = bus.mem_req && !bus.mem_ready;
    end else if (!bus.mem_ready) begin
      if (waitCnt == TIMEOUT)
        timeoutNow = 1'b1;
      else
        memStall = 1'b1;
    end
  end

  // Stall/flush priority: memory wait, then branch, then load-use; all quiet in reset.
  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    if (!rst) begin
      if (memStall) begin
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        stallM = 1'b1;
      end else if (bus.branch_taken) begin
        flushD = 1'b1;
        flushE = 1'b1;
      end else if (loadUse) begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushE = 1'b1;
      end
    end
  end

  // Next FSM state: enter MEM_WAIT on a pending request, leave on ready or timeout.
  always_comb begin
    stateNext = state;
    if (state == RUN) begin
      if (bus.mem_req && !bus.mem_ready)
        stateNext = MEM_WAIT;
    end else if (bus.mem_ready || (waitCnt == TIMEOUT)) begin
      stateNext = RUN;
    end
  end

  // FSM state, wait counter and sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      waitCnt     <= 8'd0;
      timeoutFlag <= 1'b0;
    end else begin
      state <= stateNext;
      if (state == RUN) begin
        waitCnt <= (bus.mem_req && !bus.mem_ready) ? 8'd1 : 8'd0;
      end else if (bus.mem_ready || timeoutNow) begin
        waitCnt <= 8'd0;
      end else begin
        waitCnt <= waitCnt + 8'd1;
      end
      if (timeoutNow)
        timeoutFlag <= 1'b1;
    end
  end

  // Saturating performance counters for stalled fetch cycles and flush cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCnt <= 16'd0;
      flushCnt <= 16'd0;
    end else begin
      if (stallF && (stallCnt != 16'hFFFF))
        stallCnt <= stallCnt + 16'd1;
      if ((flushD || flushE) && (flushCnt != 16'hFFFF))
        flushCnt <= flushCnt + 16'd1;
    end
  end

  // The error flag reads high from the cycle the abort happens onward.
  assign bus.mem_timeout  = timeoutFlag || timeoutNow;
  assign bus.stall_f      = stallF;
  assign bus.stall_d      = stallD;
  assign bus.stall_e      = stallE;
  assign bus.stall_m      = stallM;
  assign bus.flush_d      = flushD;
  assign bus.flush_e      = flushE;
  assign bus.stall_cycles = stallCnt;
  assign bus.flush_events = flushCnt;
  assign bus.dbgState     = state;
  assign bus.dbgWaitCnt   = waitCnt;

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter TIMEOUT, default 255, 8-bit unsigned: maximum number of cycles spent in MEM_WAIT before abort.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 d_rs1, d_rs2  in  3 each  decode-stage source register numbers.
REQ-005 d_use1, d_use2  in  1 each  decode instruction reads d_rs1 / d_rs2.
REQ-006 e_rs1, e_rs2  in  3 each  execute-stage source register numbers.
REQ-007 e_rd, e_write_reg, e_load  in  3/1/1  execute destination, register-write enable, load flag.
REQ-008 m_rd, m_write_reg  in  3/1  memory-stage destination and write enable.
REQ-009 w_rd, w_write_reg  in  3/1  writeback-stage destination and write enable.
REQ-010 branch_taken  in  1  branch resolved taken this cycle.
REQ-011 mem_req, mem_ready  in  1/1  memory-stage data access request; data memory completion.
REQ-012 stall_f, stall_d, stall_e, stall_m  out  1 each  hold the PC, decode, execute and memory pipeline registers.
REQ-013 flush_d, flush_e  out  1 each  clear the decode / execute pipeline registers to a bubble.
REQ-014 fwd_a, fwd_b  out  2 each  execute operand source: 00 register file, 10 memory-stage ALU result, 01 writeback data.
REQ-015 mem_timeout  out  1  sticky memory-timeout error flag.
REQ-016 stall_cycles, flush_events  out  16 each  performance counters.

Function
REQ-017 R0 is hardwired zero; any match where the register number is 0 SHALL be ignored for hazard and forwarding purposes.
REQ-018 fwd_a SHALL be 10 if m_write_reg and m_rd==e_rs1; else 01 if w_write_reg and w_rd==e_rs1; else 00. The memory stage wins when both match. fwd_b follows the same rule on e_rs2. These outputs are combinational.
REQ-019 load_use SHALL be e_load & e_write_reg & ((d_use1 & d_rs1==e_rd) | (d_use2 & d_rs2==e_rd)).
REQ-020 The FSM SHALL have two registered states, RUN and MEM_WAIT. Stall and flush outputs are combinational from state and inputs.
REQ-021 RUN with mem_req & !mem_ready: assert all four stalls, flush_d=flush_e=0, load wait_cnt=1, and next state MEM_WAIT. This applies the same cycle, at the highest priority.
REQ-022 MEM_WAIT with !mem_ready: all four stalls stay asserted, no flushes, and wait_cnt increments.
REQ-023 MEM_WAIT with mem_ready: all stalls deassert that cycle, next state RUN, and held branch_taken/load_use are evaluated normally in that cycle.
REQ-024 MEM_WAIT timeout: when wait_cnt==TIMEOUT and !mem_ready, set mem_timeout (sticky until rst), deassert all stalls that cycle, and move to RUN.
REQ-025 RUN, no memory stall, branch_taken: flush_d=1, flush_e=1, no stalls. Branch wins over a simultaneous load_use.
REQ-026 RUN, no memory stall, load_use, no branch: stall_f=1, stall_d=1, flush_e=1 for exactly one cycle. stall_e and stall_m stay 0.
REQ-027 Otherwise all stall and flush outputs SHALL be 0.
REQ-028 stall_cycles SHALL increment on every cycle with stall_f=1, saturating at 16'hFFFF.
REQ-029 flush_events SHALL increment once per cycle with flush_d=1 or flush_e=1, saturating at 16'hFFFF.
REQ-030 Counters and wait_cnt SHALL be registered with no combinational path from the counters to any stall or flush output.

Reset
REQ-031 While rst=1: state=RUN, wait_cnt=0, mem_timeout=0, stall_cycles=0, flush_events=0.
REQ-032 During reset, all stall/flush outputs SHALL read 0 regardless of inputs, and fwd_a/fwd_b SHALL remain combinational.
REQ-033 rst asserted mid-MEM_WAIT SHALL abort the wait immediately; the first post-reset cycle is evaluated in RUN.

Verification
REQ-034 Load-use: e_load=1, e_write_reg=1, e_rd=3, d_use1=1, d_rs1=3 -> one cycle of stall_f=stall_d=flush_e=1; stall_cycles=1, flush_events=1.
REQ-035 Forwarding: e_rs1=2, m_rd=2 and w_rd=2, both writes enabled -> fwd_a=10. With m_write_reg=0 -> fwd_a=01. With rd=0 everywhere -> 00.
REQ-036 Memory wait: mem_req=1, mem_ready=0 for 4 cycles then 1 -> all stalls high for 4 cycles, low on the ready cycle; stall_cycles=4.
REQ-037 Timeout: TIMEOUT=5, mem_ready held 0 -> stalls for 5 cycles, mem_timeout=1 from the 6th cycle, state RUN; flag persists until rst.
REQ-038 Priority: branch_taken=1 with load_use true -> flush_d=flush_e=1, stall_f=0. The same stimulus with mem_req=1, mem_ready=0 -> all stalls asserted, no flush.
REQ-039 Saturation and reset: preload stall_cycles to 16'hFFFF via sustained stall -> value holds. Pulse rst mid-MEM_WAIT -> counters 0, outputs 0.
